truth_table_capture: RTL and testbench
======================================

Name: truth_table_capture

Overview:
- Hardware counterpart of the minterm-sweep benches used for the signal-manipulation tasks.
- Drives every minterm number onto the N inputs of a combinational function under test, waits a programmable settle time, then samples the function output.
- Builds the full truth table and compares it against an expected table. Reports pass/fail, the failing-minterm count and the first failing minterm.
- Sits beside a task module on the board or in simulation as a self-check engine, started by a single pulse.

Parameters:
- N_IN, 3, number of function inputs; the sweep covers minterms 0 to 2^N_IN-1.
- SETTLE, 2, clock cycles the minterm is held before the sampling cycle (0 is legal).
- EXPECTED, 8'b0010_0100, expected truth table; bit m is the output for minterm m (default is minterms 2 and 5). Width is 2^N_IN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- drive_out  out  N_IN  minterm applied to the function under test, MSB = first input (a).
- fn_in  in  1  function output; assumed combinationally derived from drive_out.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  1 when the captured table equals EXPECTED; valid from done until the next accepted start.
- table_out  out  2^N_IN  captured truth table.
- fail_cnt  out  N_IN+1  number of mismatching minterms.
- fail_mt  out  N_IN  lowest mismatching minterm; 0 when fail_cnt is 0.

Behaviour:
- Reset is synchronous and active-high, with one clock, clk. On reset, all outputs go to 0 and the state goes to IDLE.
- A reset mid-sweep aborts the sweep immediately: no done pulse, and results are cleared.
- FSM states are IDLE, HOLD, SAMPLE and FINISH.
- IDLE:
  - drive_out = 0, busy = 0, and previous results are held.
  - start = 1 at edge k: on the same edge, load mt = 0, clear table_out, fail_cnt, fail_mt and pass, load settle_cnt = SETTLE, and go to HOLD (or to SAMPLE if SETTLE = 0).
- HOLD:
  - drive_out = mt and busy = 1.
  - settle_cnt decrements each cycle; when it reaches 1, go to SAMPLE.
- SAMPLE (one cycle, drive_out still = mt):
  - On the edge, table_out[mt] <= fn_in.
  - If fn_in != EXPECTED[mt]: increment fail_cnt, and if this is the first mismatch, fail_mt <= mt.
  - If mt = 2^N_IN-1, go to FINISH.
  - Otherwise increment mt, reload settle_cnt and go to HOLD (or back to SAMPLE when SETTLE = 0).
- FINISH (one cycle):
  - done = 1, busy = 1, and pass = (fail_cnt == 0) is registered on this edge, then go to IDLE.
  - drive_out stays at 2^N_IN-1 during FINISH and returns to 0 in IDLE.
- Timing:
  - Each minterm window is exactly SETTLE+1 cycles.
  - The done pulse occurs 2^N_IN*(SETTLE+1)+1 cycles after the start edge; for the defaults this is 25.
- start while busy is ignored.
- If start is still high in the IDLE cycle after FINISH, a new sweep begins. There is no edge detection; this is level-sampled.
- The mt counter must not wrap past 2^N_IN-1; completion is detected before the increment.
- fail_cnt is N_IN+1 bits so that "all 8 minterms fail" (= 8) is representable.

Decomposition:
- Shared package tt_capture_pkg holds:
  - the state enum (IDLE, HOLD, SAMPLE, FINISH);
  - the default N_IN;
  - the default EXPECTED constant.
- One natural sub-module, minterm_sequencer: the mt counter plus settle counter, with load/advance inputs and last/settled flags. The FSM and scoreboard live in the top.

Test Plan:
- Default function y = minterms 2 and 5, start pulse at cycle 0:
  - drive_out steps 0..7, each held 3 cycles.
  - done pulses at cycle 25, with table_out = 8'h24, pass = 1, fail_cnt = 0, fail_mt = 0.
- fn_in tied to 0: table_out = 8'h00, pass = 0, fail_cnt = 2, fail_mt = 2.
- fn_in = inverse of the expected function: table_out = 8'hDB, fail_cnt = 8, fail_mt = 0, pass = 0.
- Reset asserted while drive_out = 4:
  - the next cycle has all outputs 0 and busy = 0;
  - no done pulse appears;
  - a fresh start then completes normally at +25 cycles.
- start re-pulsed at cycles 5 and 12 during a sweep: ignored, and done still occurs once at cycle 25.
- start held high continuously: back-to-back sweeps, with done at cycles 25 and 51.
- SETTLE = 0 build: one cycle per minterm, with done at cycle 9 after start and table_out = 8'h24.

Source files
------------

// File: rtl/truth_table_capture_pkg.sv
// Shared types and defaults for the truth-table capture engine.
package tt_capture_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam int unsigned DEF_N_IN     = 3;
    localparam int unsigned DEF_SETTLE   = 2;
    // Bit m is the expected output for minterm m (minterms 2 and 5).
    localparam logic [7:0]  DEF_EXPECTED = 8'b0010_0100;

endpackage

// File: rtl/truth_table_capture_if.sv
// Bus between the capture engine and the function under test / controller.
interface truth_table_capture_if
    import tt_capture_pkg::*;
#(
    parameter int unsigned N_IN = DEF_N_IN
) ();

    logic                   start;
    logic [N_IN-1:0]        drive_out;
    logic                   fn_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [(2**N_IN)-1:0]   table_out;
    logic [N_IN:0]          fail_cnt;
    logic [N_IN-1:0]        fail_mt;

    // Capture engine side.
    modport master (
        input  start, fn_in,
        output drive_out, busy, done, pass, table_out, fail_cnt, fail_mt
    );

    // Controller / function-under-test side.
    modport slave (
        output start, fn_in,
        input  drive_out, busy, done, pass, table_out, fail_cnt, fail_mt
    );

endinterface

// File: rtl/truth_table_capture_sequencer.sv
// Minterm counter plus per-minterm settle counter.
module minterm_sequencer
    import tt_capture_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            adv_i,
    input  logic            dec_i,
    input  logic            clr_i,
    output logic [N_IN-1:0] mt_o,
    output logic            last_c,
    output logic            settled_c
);

    localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    logic [N_IN-1:0] mt_q, mt_d;
    logic [SW-1:0]   settle_q, settle_d;

    // Next-state: clear wins, then load, advance, settle countdown.
    always_comb begin
        mt_d     = mt_q;
        settle_d = settle_q;
        if (clr_i) begin
            mt_d     = '0;
            settle_d = '0;
        end else if (load_i) begin
            mt_d     = '0;
            settle_d = SW'(SETTLE);
        end else if (adv_i) begin
            mt_d     = mt_q + N_IN'(1);
            settle_d = SW'(SETTLE);
        end else if (dec_i && (settle_q != '0)) begin
            settle_d = settle_q - SW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mt_q     <= '0;
            settle_q <= '0;
        end else begin
            mt_q     <= mt_d;
            settle_q <= settle_d;
        end
    end

    assign mt_o      = mt_q;
    assign last_c    = (mt_q == '1);
    // Settled once the countdown is at 1 (or 0): this is the last hold cycle.
    assign settled_c = ((settle_q >> 1) == '0);

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps all minterms, captures the function output and scores it.
module truth_table_capture
    import tt_capture_pkg::*;
#(
    parameter int unsigned          N_IN     = DEF_N_IN,
    parameter int unsigned          SETTLE   = DEF_SETTLE,
    parameter logic [2**N_IN-1:0]   EXPECTED = DEF_EXPECTED
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_capture_if.master bus
);

    localparam int unsigned N_MT = 2**N_IN;
    localparam int unsigned CW   = N_IN + 1;
    // First state of each minterm window; HOLD is skipped with no settle time.
    localparam state_e WIN_START = state_e'((SETTLE == 0) ? SAMPLE : HOLD);

    state_e          state_q, state_d;
    logic            seq_load, seq_adv, seq_dec, seq_clr;
    logic [N_IN-1:0] mt;
    logic            mt_last, mt_settled;
    logic            mismatch_c;

    logic [N_MT-1:0] table_q, table_d;
    logic [CW-1:0]   fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0] fail_mt_q, fail_mt_d;
    logic            pass_q, pass_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    minterm_sequencer #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .load_i    (seq_load),
        .adv_i     (seq_adv),
        .dec_i     (seq_dec),
        .clr_i     (seq_clr),
        .mt_o      (mt),
        .last_c    (mt_last),
        .settled_c (mt_settled)
    );

    assign mismatch_c = (bus.fn_in != EXPECTED[mt]);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, sequencer control and scoreboard next values.
    always_comb begin
        state_d    = state_q;
        seq_load   = 1'b0;
        seq_adv    = 1'b0;
        seq_dec    = 1'b0;
        seq_clr    = 1'b0;
        table_d    = table_q;
        fail_cnt_d = fail_cnt_q;
        fail_mt_d  = fail_mt_q;
        pass_d     = pass_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seq_load   = 1'b1;
                    table_d    = '0;
                    fail_cnt_d = '0;
                    fail_mt_d  = '0;
                    pass_d     = 1'b0;
                    state_d    = WIN_START;
                end
            end
            HOLD: begin
                seq_dec = 1'b1;
                if (mt_settled) state_d = SAMPLE;
            end
            SAMPLE: begin
                table_d[mt] = bus.fn_in;
                if (mismatch_c) begin
                    fail_cnt_d = fail_cnt_q + CW'(1);
                    if (fail_cnt_q == '0) fail_mt_d = mt;
                end
                // Completion is checked before advancing so mt never wraps.
                if (mt_last) begin
                    state_d = FINISH;
                end else begin
                    seq_adv = 1'b1;
                    state_d = WIN_START;
                end
            end
            FINISH: begin
                seq_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
        if (state_d == FINISH) pass_d = (fail_cnt_d == '0);
    end

    // Result and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            table_q    <= '0;
            fail_cnt_q <= '0;
            fail_mt_q  <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            table_q    <= table_d;
            fail_cnt_q <= fail_cnt_d;
            fail_mt_q  <= fail_mt_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.drive_out = mt;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.table_out = table_q;
    assign bus.fail_cnt  = fail_cnt_q;
    assign bus.fail_mt   = fail_mt_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Scoreboard bench for truth_table_capture (SETTLE=2 and SETTLE=0 builds).
module tb_truth_table_capture;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [3:0] cnt;
        logic [2:0] mt;
        int         cyc;
    } exp_t;

    localparam logic [7:0] FN_TBL = 8'h24;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mode_fn = 0;   // 0: good function, 1: stuck at 0, 2: inverted
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_capture_if #(.N_IN(3)) bus_a ();
    truth_table_capture_if #(.N_IN(3)) bus_b ();

    truth_table_capture #(.N_IN(3), .SETTLE(2), .EXPECTED(8'b0010_0100)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    truth_table_capture #(.N_IN(3), .SETTLE(0), .EXPECTED(8'b0010_0100)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Function under test for each engine.
    always_comb begin
        case (mode_fn)
            1:       bus_a.fn_in = 1'b0;
            2:       bus_a.fn_in = ~FN_TBL[bus_a.drive_out];
            default: bus_a.fn_in = FN_TBL[bus_a.drive_out];
        endcase
    end

    always_comb begin
        case (mode_fn)
            1:       bus_b.fn_in = 1'b0;
            2:       bus_b.fn_in = ~FN_TBL[bus_b.drive_out];
            default: bus_b.fn_in = FN_TBL[bus_b.drive_out];
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [7:0] tbl, input logic p,
                         input logic [3:0] c, input logic [2:0] m, input logic b);
        check({tag, "_table"},    32'(tbl), 32'(e.tbl));
        check({tag, "_pass"},     32'(p),   32'(e.pass));
        check({tag, "_fail_cnt"}, 32'(c),   32'(e.cnt));
        check({tag, "_fail_mt"},  32'(m),   32'(e.mt));
        check({tag, "_done_cyc"}, 32'(cyc), 32'(e.cyc));
        check({tag, "_busy"},     32'(b),   32'(1));
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.done === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_done at cycle %0d", cyc);
            end else begin
                e = qa.pop_front();
                score("a", e, bus_a.table_out, bus_a.pass, bus_a.fail_cnt, bus_a.fail_mt, bus_a.busy);
            end
        end
        if (bus_b.done === 1'b1) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_done at cycle %0d", cyc);
            end else begin
                e = qb.pop_front();
                score("b", e, bus_b.table_out, bus_b.pass, bus_b.fail_cnt, bus_b.fail_mt, bus_b.busy);
            end
        end
    end

    // Wait for a scoreboard queue to drain within a cycle budget.
    task automatic wait_drain(input bit sel_b, input int budget);
        int n = 0;
        while (((sel_b ? qb.size() : qa.size()) != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if ((sel_b ? qb.size() : qa.size()) != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_done_timeout at cycle %0d: got no done expected done", sel_b ? "b" : "a", cyc);
            if (sel_b) qb.delete();
            else       qa.delete();
        end
    endtask

    task automatic idle_check_a(input string tag);
        @(negedge clk);
        check({tag, "_idle_busy"},  32'(bus_a.busy),      32'(0));
        check({tag, "_idle_drive"}, 32'(bus_a.drive_out), 32'(0));
        check({tag, "_idle_done"},  32'(bus_a.done),      32'(0));
    endtask

    task automatic pulse_start_a(output int s);
        @(negedge clk);
        bus_a.start = 1'b1;
        s = cyc;
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    initial begin
        int s;
        int n;
        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_busy",     32'(bus_a.busy),      32'(0));
        check("rst_done",     32'(bus_a.done),      32'(0));
        check("rst_pass",     32'(bus_a.pass),      32'(0));
        check("rst_table",    32'(bus_a.table_out), 32'(0));
        check("rst_fail_cnt", 32'(bus_a.fail_cnt),  32'(0));
        check("rst_fail_mt",  32'(bus_a.fail_mt),   32'(0));
        check("rst_drive",    32'(bus_a.drive_out), 32'(0));
        check("rst_b_busy",   32'(bus_b.busy),      32'(0));
        reset = 1'b0;

        // Correct function: drive_out steps every 3 cycles, pass at +25.
        mode_fn = 0;
        @(negedge clk);
        bus_a.start = 1'b1;
        s = cyc;
        qa.push_back('{tbl: 8'h24, pass: 1'b1, cnt: 4'd0, mt: 3'd0, cyc: s + 25});
        @(negedge clk);
        bus_a.start = 1'b0;
        for (int m = 0; m < 8; m++) begin
            while (cyc < s + 2 + 3 * m) @(negedge clk);
            check("a_drive_step", 32'(bus_a.drive_out), 32'(m));
        end
        wait_drain(1'b0, 60);
        idle_check_a("good");

        // Output stuck at 0: minterms 2 and 5 fail.
        mode_fn = 1;
        pulse_start_a(s);
        qa.push_back('{tbl: 8'h00, pass: 1'b0, cnt: 4'd2, mt: 3'd2, cyc: s + 25});
        wait_drain(1'b0, 60);
        idle_check_a("zero");

        // Inverted function: every minterm fails.
        mode_fn = 2;
        pulse_start_a(s);
        qa.push_back('{tbl: 8'hDB, pass: 1'b0, cnt: 4'd8, mt: 3'd0, cyc: s + 25});
        wait_drain(1'b0, 60);
        idle_check_a("inv");

        // Reset mid-sweep at minterm 4: aborted, no done, then a clean rerun.
        mode_fn = 0;
        pulse_start_a(s);
        n = 0;
        while ((bus_a.drive_out !== 3'd4) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_mt4", 32'(bus_a.drive_out), 32'(4));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",     32'(bus_a.busy),      32'(0));
        check("abort_drive",    32'(bus_a.drive_out), 32'(0));
        check("abort_table",    32'(bus_a.table_out), 32'(0));
        check("abort_fail_cnt", 32'(bus_a.fail_cnt),  32'(0));
        check("abort_done",     32'(bus_a.done),      32'(0));
        repeat (30) @(negedge clk);
        pulse_start_a(s);
        qa.push_back('{tbl: 8'h24, pass: 1'b1, cnt: 4'd0, mt: 3'd0, cyc: s + 25});
        wait_drain(1'b0, 60);
        idle_check_a("rerun");

        // start re-pulsed while busy is ignored.
        pulse_start_a(s);
        qa.push_back('{tbl: 8'h24, pass: 1'b1, cnt: 4'd0, mt: 3'd0, cyc: s + 25});
        while (cyc < s + 5) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        while (cyc < s + 12) @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        wait_drain(1'b0, 60);
        idle_check_a("repulse");

        // start held high: back-to-back sweeps.
        @(negedge clk);
        bus_a.start = 1'b1;
        s = cyc;
        qa.push_back('{tbl: 8'h24, pass: 1'b1, cnt: 4'd0, mt: 3'd0, cyc: s + 25});
        qa.push_back('{tbl: 8'h24, pass: 1'b1, cnt: 4'd0, mt: 3'd0, cyc: s + 51});
        while (cyc < s + 30) @(negedge clk);
        bus_a.start = 1'b0;
        wait_drain(1'b0, 80);
        idle_check_a("b2b");

        // SETTLE = 0 build: one cycle per minterm.
        @(negedge clk);
        bus_b.start = 1'b1;
        s = cyc;
        qb.push_back('{tbl: 8'h24, pass: 1'b1, cnt: 4'd0, mt: 3'd0, cyc: s + 9});
        @(negedge clk);
        bus_b.start = 1'b0;
        wait_drain(1'b1, 30);
        @(negedge clk);
        check("b_idle_busy",  32'(bus_b.busy),      32'(0));
        check("b_idle_drive", 32'(bus_b.drive_out), 32'(0));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
